// File: rtl/mux_arb_reg.sv
// Registered N-channel multiplexer with valid/ready handshaking.
// Arbitration is fixed priority, round-robin or forced selection, chosen by mode.
module mux_arb_reg #(
  parameter int WIDTH = 16,
  parameter int NCH   = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [1:0]           mode,
  input  logic [SELW-1:0]      force_sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_sel,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [15:0]          xfer_cnt
);

  logic [SELW-1:0] r_rr_ptr;
  logic            w_load_en;
  logic            w_gnt_vld;
  logic [SELW-1:0] w_gnt_idx;
  logic            w_xfer;

  assign w_load_en = !out_valid || out_ready;
  assign w_xfer    = w_load_en && w_gnt_vld && !rst;

  // Grant selection; loops scan backwards so the last hit is the highest-priority one.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    case (mode)
      2'b01: begin
        for (int k = NCH; k >= 1; k--) begin
          if (in_valid[(int'(r_rr_ptr) + k) % NCH]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = SELW'((int'(r_rr_ptr) + k) % NCH);
          end else begin
            w_gnt_vld = w_gnt_vld;
          end
        end
      end
      2'b10: begin
        if ((int'(force_sel) < NCH) && in_valid[force_sel]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = force_sel;
        end else begin
          w_gnt_vld = 1'b0;
        end
      end
      default: begin
        for (int k = NCH - 1; k >= 0; k--) begin
          if (in_valid[k]) begin
            w_gnt_vld = 1'b1;
            w_gnt_idx = SELW'(k);
          end else begin
            w_gnt_vld = w_gnt_vld;
          end
        end
      end
    endcase
  end

  // One-hot accept toward the granted producer.
  always_comb begin
    in_ready = '0;
    if (w_xfer) begin
      in_ready = NCH'(1) << w_gnt_idx;
    end else begin
      in_ready = '0;
    end
  end

  // Output register, transfer counter and round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      xfer_cnt  <= 16'h0000;
      r_rr_ptr  <= SELW'(NCH - 1);
    end else if (w_xfer) begin
      out_data  <= in_data[w_gnt_idx*WIDTH +: WIDTH];
      out_sel   <= w_gnt_idx;
      out_valid <= 1'b1;
      xfer_cnt  <= xfer_cnt + 16'h0001;
      r_rr_ptr  <= w_gnt_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_arb_reg.sv
// Directed self-checking bench for mux_arb_reg (NCH=4 main instance, NCH=3 for illegal force_sel).
module tb_mux_arb_reg;

  logic        clk;
  logic        rst;
  logic [1:0]  mode;
  logic [1:0]  force_sel;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic [3:0]  in_ready;
  logic [15:0] out_data;
  logic [1:0]  out_sel;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] xfer_cnt;

  logic [1:0]  b_mode;
  logic [1:0]  b_force_sel;
  logic [47:0] b_in_data;
  logic [2:0]  b_in_valid;
  logic [2:0]  b_in_ready;
  logic [15:0] b_out_data;
  logic [1:0]  b_out_sel;
  logic        b_out_valid;
  logic        b_out_ready;
  logic [15:0] b_xfer_cnt;

  int n_total = 0;
  int n_fail  = 0;

  mux_arb_reg #(.WIDTH(16), .NCH(4), .SELW(2)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .force_sel(force_sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
    .out_ready(out_ready), .xfer_cnt(xfer_cnt)
  );

  mux_arb_reg #(.WIDTH(16), .NCH(3), .SELW(2)) u_dut3 (
    .clk(clk), .rst(rst), .mode(b_mode), .force_sel(b_force_sel),
    .in_data(b_in_data), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .out_data(b_out_data), .out_sel(b_out_sel), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .xfer_cnt(b_xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; mode = 2'b00; force_sel = 2'd0;
    in_data = {16'h333D, 16'h222C, 16'h111B, 16'h000A};
    in_valid = 4'b1111; out_ready = 1'b1;
    b_mode = 2'b00; b_force_sel = 2'd0;
    b_in_data = {16'hCCC2, 16'hBBB1, 16'hAAA0};
    b_in_valid = 3'b000; b_out_ready = 1'b1;

    // reset held three cycles with every channel requesting
    for (int i = 0; i < 3; i++) begin
      #1 chk("rst_ready", in_ready, 0);
      cyc();
      chk("rst_valid", out_valid, 0);
      chk("rst_cnt", xfer_cnt, 0);
      chk("rst_data", out_data, 0);
    end
    rst = 1'b0;
    #1 chk("first_ready", in_ready, 4'b0001);
    cyc();
    chk("first_sel", out_sel, 0);
    chk("first_data", out_data, 16'h000A);
    chk("first_valid", out_valid, 1);
    chk("first_cnt", xfer_cnt, 1);

    // fixed priority
    in_valid = 4'b1010;
    for (int i = 0; i < 3; i++) begin
      #1 chk("fp_ready", in_ready, 4'b0010);
      cyc();
      chk("fp_data", out_data, 16'h111B);
      chk("fp_sel", out_sel, 1);
      chk("fp_cnt", xfer_cnt, 2 + i);
    end
    mode = 2'b11; in_valid = 4'b1100;
    #1 chk("mode11_ready", in_ready, 4'b0100);

    // round-robin from a fresh reset
    rst = 1'b1; cyc(); rst = 1'b0;
    mode = 2'b01; in_valid = 4'b1111;
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("rr_sel", out_sel, i % 4);
    end
    chk("rr_cnt", xfer_cnt, 6);

    // backpressure
    cyc();
    chk("bp_first_sel", out_sel, 2);
    chk("bp_first_cnt", xfer_cnt, 7);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1 chk("bp_ready", in_ready, 0);
      cyc();
      chk("bp_data", out_data, 16'h222C);
      chk("bp_valid", out_valid, 1);
      chk("bp_cnt", xfer_cnt, 7);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 4'b1000);
    cyc();
    chk("bp_release_sel", out_sel, 3);
    chk("bp_release_data", out_data, 16'h333D);
    chk("bp_release_cnt", xfer_cnt, 8);

    // forced select, then rr pointer follows forced grant
    mode = 2'b10; force_sel = 2'd2; in_valid = 4'b0101;
    #1 chk("force_ready", in_ready, 4'b0100);
    cyc();
    chk("force_sel_out", out_sel, 2);
    chk("force_cnt", xfer_cnt, 9);
    mode = 2'b01; in_valid = 4'b1111;
    #1 chk("rr_after_force", in_ready, 4'b1000);
    in_valid = 4'b0000;
    cyc();
    chk("drain_valid", out_valid, 0);
    chk("drain_sel", out_sel, 2);
    chk("drain_data", out_data, 16'h222C);
    chk("drain_cnt", xfer_cnt, 9);

    // illegal force_sel on NCH=3 instance
    b_in_valid = 3'b111;
    cyc();
    chk("b_load_valid", b_out_valid, 1);
    chk("b_load_data", b_out_data, 16'hAAA0);
    b_mode = 2'b10; b_force_sel = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1 chk("b_illegal_ready", b_in_ready, 0);
      cyc();
      chk("b_illegal_valid", b_out_valid, 0);
      chk("b_illegal_cnt", b_xfer_cnt, 1);
    end

    // mid-stream reset drops held word without counting
    mode = 2'b00; in_valid = 4'b0001;
    cyc();
    chk("pre_rst_valid", out_valid, 1);
    chk("pre_rst_cnt", xfer_cnt, 10);
    rst = 1'b1; in_valid = 4'b1111;
    #1 chk("mid_rst_ready", in_ready, 0);
    cyc();
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_cnt", xfer_cnt, 0);
    rst = 1'b0;

    // counter wrap
    for (int i = 0; i < 65534; i++) cyc();
    chk("wrap_pre", xfer_cnt, 16'hFFFE);
    cyc();
    chk("wrap_ffff", xfer_cnt, 16'hFFFF);
    cyc();
    chk("wrap_zero", xfer_cnt, 16'h0000);
    chk("wrap_valid", out_valid, 1);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule

// File: doc/mux_arb_reg.md
# mux_arb_reg

Parametrised, registered N-channel multiplexer with valid/ready handshaking and selectable arbitration mode. It replaces the combinational 16-bit select mux wherever several producers share one datapath. Each cycle it picks one requesting channel by fixed priority, round-robin or forced selection, and latches that channel's word into a single output register. The register is pipelined for full throughput.

## Interface
Parameters:
- WIDTH, 16: data word width per channel.
- NCH, 4: number of input channels; legal range 2..16.
- SELW, 2: channel index width; must equal ceil(log2(NCH)).

Ports:
- clk  input  1  rising-edge clock; sole clock domain.
- rst  input  1  synchronous, active-high reset.
- mode  input  2  arbitration mode: 00 fixed priority, 01 round-robin, 10 forced, 11 treated as 00.
- force_sel  input  SELW  channel index used in forced mode.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel request.
- in_ready  output  NCH  per-channel accept; at most one bit high.
- out_data  output  WIDTH  registered selected word.
- out_sel  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  downstream accept.
- xfer_cnt  output  16  count of accepted input transfers; wraps 0xFFFF -> 0x0000.

## Operation
- load_en = !out_valid || out_ready. The output register may load on any cycle where load_en is true.
- Grant is combinational from in_valid, mode, force_sel and rr_ptr. There is no grant when no eligible channel is valid.
- Mode 00 and 11: the lowest-index valid channel wins.
- Mode 01: the search starts at rr_ptr+1 and wraps modulo NCH. The first valid channel found wins.
- Mode 10: only channel force_sel is eligible. If force_sel >= NCH, nothing is eligible and no grant is made.
- in_ready[g] = load_en && grant exists && !rst, where g is the granted index. All other in_ready bits are 0.
- Transfer on channel g: in_valid[g] && in_ready[g]. On a transfer, at the next edge:
  - out_data <= word g,
  - out_sel <= g,
  - out_valid <= 1,
  - xfer_cnt <= xfer_cnt+1,
  - rr_ptr <= g.
- rr_ptr updates only on an accepted transfer, and in every mode, so that round-robin resumes fairly after a mode switch.
- If out_valid && out_ready and there is no transfer, out_valid <= 0. out_data and out_sel keep their last values.
- If out_valid && !out_ready, out_data, out_sel and out_valid hold, and all in_ready bits are 0.
- A mode or force_sel change affects arbitration from the same cycle onward. It never disturbs a word already in the output register.
- Reset values: out_valid=0, out_data=0, out_sel=0, xfer_cnt=0, rr_ptr=NCH-1 (channel 0 is first in round-robin). in_ready is all-0 while rst is high.
- Reset asserted mid-operation discards any held word with no handshake. An upstream word presented during reset is not accepted.

## Timing
- Latency: an accept at edge k makes the word visible on out_data with out_valid=1 after edge k.
- Throughput: one word per cycle while out_ready is held high and a request is present.
- in_ready depends combinationally on out_ready, out_valid, in_valid, mode and force_sel. It does not depend on in_data.
- A simultaneous downstream consume (out_ready) and new accept in the same cycle is legal. The register is overwritten and out_valid stays 1.
- The first cycle after rst deasserts may accept. in_ready is valid combinationally in that cycle.
- xfer_cnt wrap is silent, with no flag.

## Test plan
- Reset check: hold rst 3 cycles with in_valid=4'b1111 and out_ready=1. Required: in_ready=0, out_valid=0, xfer_cnt=0 throughout. After release, the first accept is channel 0.
- Fixed priority: mode=00, in_valid=4'b1010, channel data 0x000A/0x111B/0x222C/0x333D, out_ready=1. Required: channel 1 granted every cycle, out_data=0x111B, out_sel=1.
- Round-robin: mode=01, in_valid=4'b1111, out_ready=1 for 6 cycles. Required: out_sel sequence 0,1,2,3,0,1 and xfer_cnt=6.
- Backpressure: mode=01, out_ready=0 after the first accept, held 4 cycles. Required: out_data held, in_ready=0, xfer_cnt frozen. On out_ready=1, the next channel in rotation is accepted on that same cycle.
- Forced and illegal select: mode=10, force_sel=2 gives only channel 2 accepted even when channel 0 is valid. With NCH=3 and force_sel=3, no in_ready ever asserts and out_valid drains to 0.
- Counter wrap and mid-stream reset: preload 0xFFFE transfers (or force), then 2 accepts give xfer_cnt 0xFFFF then 0x0000. Asserting rst while out_valid=1 clears out_valid the next cycle with no transfer counted.
